input_ctrl_router: RTL and testbench
====================================

// Module: input_ctrl_router
// PURPOSE
// - Receive side of a router port: accepts WIDTH_packet-bit packets on one 4-phase req/ack input channel.
// - Buffers them in a small FIFO and XY-decodes the destination of each packet.
// - Delivers each packet on one of five 4-phase output channels (LOCAL/N/E/S/W).
// - Feeds the per-direction output controllers (4:1 arbiter trees); one instance per router input port.
// PARAMETERS
// - WIDTH_packet  57  packet width; bits [WIDTH_packet-1 -: 2*ADDR_W] = {dest_x, dest_y}
// - ADDR_W        2   width of each destination coordinate
// - MY_X          0   this router's x coordinate
// - MY_Y          0   this router's y coordinate
// - DEPTH         2   FIFO entries, power of 2, >=2
// PORTS
// - clk       in   1             single clock, all logic on posedge
// - reset     in   1             synchronous, active-high
// - in_req    in   1             input channel request (4-phase)
// - in_data   in   WIDTH_packet  input packet, stable while in_req=1
// - in_ack    out  1             input channel acknowledge
// - out_req   out  5             one-hot output requests, index = port enum
// - out_ack   in   5             per-port output acknowledges
// - out_data  out  WIDTH_packet  shared output packet bus, valid while any out_req=1
// BEHAVIOUR
// - Reset: in_ack=0, out_req=5'b0, out_data=0, FIFO empty (count=0, ptrs=0), both FSMs to IDLE.
// - Reset is honoured in any state; in-flight handshakes are abandoned, buffered packets dropped.
// - Route decode on FIFO head, in this order:
//   - dx>MY_X: EAST
//   - dx<MY_X: WEST
//   - dy>MY_Y: NORTH
//   - dy<MY_Y: SOUTH
//   - otherwise: LOCAL
//   - Comparisons are unsigned.
// - Input FSM {IN_IDLE, IN_ACK}:
//   - IN_IDLE and in_req=1 and !full: write in_data to FIFO, in_ack<=1, go to IN_ACK.
//   - IN_IDLE and full: hold in_ack=0; never drop or overwrite a packet.
//   - IN_ACK and in_req=0: in_ack<=0, go to IN_IDLE. Exactly one FIFO write per 4-phase cycle.
// - Output FSM {OUT_IDLE, OUT_REQ, OUT_REL}; holds the selected port index in sel:
//   - OUT_IDLE and !empty: out_data<=head, sel<=route(head), out_req[route]<=1, go to OUT_REQ.
//   - OUT_REQ and out_ack[sel]=1: out_req<=0, pop FIFO, go to OUT_REL.
//   - OUT_REL and out_ack[sel]=0: go to OUT_IDLE.
//   - out_ack bits other than sel are ignored.
//   - At most one out_req bit high at any time; out_data is stable while out_req!=0.
// - Latency, empty FIFO: in_req sampled high at edge n -> in_ack and count update after edge n;
//   out_req high after edge n+1. There is no bypass path.
// - Simultaneous push and pop in one cycle: count unchanged; the pop is applied to the old head.
// - Full (count=DEPTH) blocks new writes only. A pop in the same cycle does not unblock the write until the next cycle.
// - FIFO pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
// - Packets leave in arrival order (single FIFO, head-of-line blocking is accepted).
// STRUCTURE
// - noc_pkg holds: typedef enum logic[2:0] {PORT_LOCAL=0, PORT_NORTH=1, PORT_EAST=2, PORT_SOUTH=3, PORT_WEST=4} port_e;
//   the NUM_PORTS=5 constant; and the dest-field offset localparams.
// - Sub-module noc_pkt_fifo(clk, reset, push, push_data, pop, head, full, empty): synchronous FIFO with DEPTH entries.
// - Route decode is a function route_xy() in noc_pkg, shared with the output controller's checks.
// TESTING
// - Test parameters: MY_X=1, MY_Y=1, ADDR_W=2, WIDTH_packet=57.
// - T1 reset: assert reset 3 cycles mid-handshake (in_ack=1, out_req=5'b00100) -> all outputs 0 on the next edge, FIFO empty.
// - T2 routing: send 5 packets with dest {x,y}=(2,1),(0,1),(1,2),(1,0),(1,1) and ack immediately
//   -> out_req = 00100, 10000, 00010, 01000, 00001 in order; out_data equals each sent packet.
// - T3 latency: empty FIFO, in_req rises before edge n -> in_ack=1 after edge n; out_req=00100 after edge n+1 (dest (3,1)).
// - T4 backpressure: hold out_ack=0 and send 3 packets -> first two acked; third sees in_ack=0.
//   Release out_ack -> third acked one cycle after count drops below 2; order preserved.
// - T5 ack isolation: while out_req=00100 drive out_ack=00010
//   -> no pop, out_req holds; then out_ack=00100 -> out_req=0 next cycle.
// - T6 throughput: back-to-back input and eager output acks over 100 random-dest packets
//   -> scoreboard shows zero loss and zero duplication, strict order, one-hot out_req always.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC router types: port enumeration, destination field layout and
// the XY route decode used by the input controllers and output-side checks.
package noc_pkg;

    typedef enum logic [2:0] {
        PORT_LOCAL = 3'd0,
        PORT_NORTH = 3'd1,
        PORT_EAST  = 3'd2,
        PORT_SOUTH = 3'd3,
        PORT_WEST  = 3'd4
    } port_e;

    localparam int NUM_PORTS        = 5;
    localparam int COORD_W          = 8;
    localparam int DEF_WIDTH_PACKET = 57;
    localparam int DEF_ADDR_W       = 2;

    // Destination fields counted down from the packet MSB, ADDR_W bits each.
    localparam int DEST_X_FIELD = 0;
    localparam int DEST_Y_FIELD = 1;

    // Dimension-ordered routing: resolve x first, then y; unsigned compares.
    function automatic port_e route_xy(
        input logic [COORD_W-1:0] dx,
        input logic [COORD_W-1:0] dy,
        input logic [COORD_W-1:0] my_x,
        input logic [COORD_W-1:0] my_y
    );
        port_e dir;
        if (dx > my_x) begin
            dir = PORT_EAST;
        end else if (dx < my_x) begin
            dir = PORT_WEST;
        end else if (dy > my_y) begin
            dir = PORT_NORTH;
        end else if (dy < my_y) begin
            dir = PORT_SOUTH;
        end else begin
            dir = PORT_LOCAL;
        end
        return dir;
    endfunction

    function automatic logic [NUM_PORTS-1:0] port_onehot(input port_e p);
        logic [NUM_PORTS-1:0] oh;
        case (p)
            PORT_LOCAL: oh = 5'b00001;
            PORT_NORTH: oh = 5'b00010;
            PORT_EAST:  oh = 5'b00100;
            PORT_SOUTH: oh = 5'b01000;
            PORT_WEST:  oh = 5'b10000;
            default:    oh = 5'b00000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/noc_pkt_fifo.sv
// Synchronous packet FIFO; head is the oldest entry, push is refused when full
// and pop is refused when empty.
module noc_pkt_fifo import noc_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH_PACKET,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign head      = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy; pointers wrap at the power-of-2 depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/input_ctrl_router.sv
// Router input port: 4-phase receive into a packet FIFO, XY route decode of the
// head packet and 4-phase delivery on one of five one-hot output channels.
module input_ctrl_router import noc_pkg::*; #(
    parameter int WIDTH_packet = DEF_WIDTH_PACKET,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int MY_X         = 0,
    parameter int MY_Y         = 0,
    parameter int DEPTH        = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_req,
    input  logic [WIDTH_packet-1:0] in_data,
    output logic                    in_ack,
    output logic [NUM_PORTS-1:0]    out_req,
    input  logic [NUM_PORTS-1:0]    out_ack,
    output logic [WIDTH_packet-1:0] out_data
);

    typedef enum logic {IN_IDLE = 1'b0, IN_ACK = 1'b1} in_state_e;
    typedef enum logic [1:0] {OUT_IDLE = 2'd0, OUT_REQ = 2'd1, OUT_REL = 2'd2} out_state_e;

    localparam int X_MSB = WIDTH_packet - 1 - DEST_X_FIELD * ADDR_W;
    localparam int Y_MSB = WIDTH_packet - 1 - DEST_Y_FIELD * ADDR_W;

    in_state_e                in_state_r, in_state_s;
    out_state_e               out_state_r, out_state_s;
    logic                     in_ack_r, in_ack_s;
    logic [NUM_PORTS-1:0]     out_req_r, out_req_s;
    logic [WIDTH_packet-1:0]  out_data_r, out_data_s;
    port_e                    sel_r, sel_s;
    logic                     push_s, pop_s;
    logic [WIDTH_packet-1:0]  head_s;
    logic                     full_s, empty_s;
    logic [ADDR_W-1:0]        dest_x_s, dest_y_s;
    port_e                    route_s;

    noc_pkt_fifo #(.WIDTH(WIDTH_packet), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (in_data),
        .pop       (pop_s),
        .head      (head_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    assign dest_x_s = head_s[X_MSB -: ADDR_W];
    assign dest_y_s = head_s[Y_MSB -: ADDR_W];
    assign route_s  = route_xy(COORD_W'(dest_x_s), COORD_W'(dest_y_s),
                               COORD_W'(MY_X), COORD_W'(MY_Y));

    // Input handshake: one FIFO write per 4-phase cycle, stall while full.
    always_comb begin
        in_state_s = in_state_r;
        in_ack_s   = in_ack_r;
        push_s     = 1'b0;
        case (in_state_r)
            IN_IDLE: begin
                if (in_req && !full_s) begin
                    push_s     = 1'b1;
                    in_ack_s   = 1'b1;
                    in_state_s = IN_ACK;
                end else begin
                    in_ack_s   = 1'b0;
                end
            end
            IN_ACK: begin
                if (!in_req) begin
                    in_ack_s   = 1'b0;
                    in_state_s = IN_IDLE;
                end else begin
                    in_ack_s   = 1'b1;
                end
            end
            default: begin
                in_ack_s   = 1'b0;
                in_state_s = IN_IDLE;
            end
        endcase
    end

    // Output handshake: the head leaves the FIFO only once its own port acks.
    always_comb begin
        out_state_s = out_state_r;
        out_req_s   = out_req_r;
        out_data_s  = out_data_r;
        sel_s       = sel_r;
        pop_s       = 1'b0;
        case (out_state_r)
            OUT_IDLE: begin
                if (!empty_s) begin
                    out_data_s  = head_s;
                    sel_s       = route_s;
                    out_req_s   = port_onehot(route_s);
                    out_state_s = OUT_REQ;
                end else begin
                    out_req_s   = {NUM_PORTS{1'b0}};
                end
            end
            OUT_REQ: begin
                if (out_ack[sel_r]) begin
                    out_req_s   = {NUM_PORTS{1'b0}};
                    pop_s       = 1'b1;
                    out_state_s = OUT_REL;
                end else begin
                    out_req_s   = out_req_r;
                end
            end
            OUT_REL: begin
                if (!out_ack[sel_r]) begin
                    out_state_s = OUT_IDLE;
                end else begin
                    out_state_s = OUT_REL;
                end
            end
            default: begin
                out_req_s   = {NUM_PORTS{1'b0}};
                out_state_s = OUT_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any handshake in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_state_r  <= IN_IDLE;
            out_state_r <= OUT_IDLE;
            in_ack_r    <= 1'b0;
            out_req_r   <= {NUM_PORTS{1'b0}};
            out_data_r  <= {WIDTH_packet{1'b0}};
            sel_r       <= PORT_LOCAL;
        end else begin
            in_state_r  <= in_state_s;
            out_state_r <= out_state_s;
            in_ack_r    <= in_ack_s;
            out_req_r   <= out_req_s;
            out_data_r  <= out_data_s;
            sel_r       <= sel_s;
        end
    end

    assign in_ack   = in_ack_r;
    assign out_req  = out_req_r;
    assign out_data = out_data_r;

endmodule

// File: tb/tb_input_ctrl_router.sv
// Self-checking bench for input_ctrl_router at MY_X=1, MY_Y=1: directed tests
// plus an in-order scoreboard checked every cycle by a monitor process.
module tb_input_ctrl_router;

    localparam int W = 57;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_req;
    logic [W-1:0] in_data;
    logic         in_ack;
    logic [4:0]   out_req;
    logic [4:0]   out_ack = 5'b00000;
    logic [W-1:0] out_data;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];
    logic [4:0]   req_log[$];
    logic [W-1:0] data_log[$];
    int           recv_count = 0;
    bit           auto_ack   = 1'b0;
    logic [4:0]   manual_ack = 5'b00000;

    input_ctrl_router #(
        .WIDTH_packet (W),
        .ADDR_W       (2),
        .MY_X         (1),
        .MY_Y         (1),
        .DEPTH        (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_req   (in_req),
        .in_data  (in_data),
        .in_ack   (in_ack),
        .out_req  (out_req),
        .out_ack  (out_ack),
        .out_data (out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=completion", name);
    endtask

    // Expected one-hot port from the routing rules for a router at (1,1).
    function automatic logic [4:0] exp_onehot(input logic [W-1:0] p);
        int dx, dy, dir;
        dx = int'(p[W-1 -: 2]);
        dy = int'(p[W-3 -: 2]);
        if (dx != 1)      dir = (dx > 1) ? 2 : 4;
        else if (dy != 1) dir = (dy > 1) ? 1 : 3;
        else              dir = 0;
        return 5'(1 << dir);
    endfunction

    function automatic logic [W-1:0] mk(input int dx, input int dy);
        logic [52:0] pl;
        pl = 53'({$urandom(), $urandom()});
        return {2'(dx), 2'(dy), pl};
    endfunction

    task automatic send(input logic [W-1:0] p);
        int n;
        n = 0;
        while (in_ack !== 1'b0 && n < 50) begin @(posedge clk); #1; n++; end
        exp_q.push_back(p);
        in_data = p;
        in_req  = 1'b1;
        n = 0;
        while (in_ack !== 1'b1 && n < 300) begin @(posedge clk); #1; n++; end
        if (in_ack !== 1'b1) tmo("send_ack");
        in_req = 1'b0;
        n = 0;
        while (in_ack !== 1'b0 && n < 50) begin @(posedge clk); #1; n++; end
        if (in_ack !== 1'b0) tmo("send_release");
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_req != 5'b00000) && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        if (exp_q.size() != 0 || out_req != 5'b00000) tmo("drain");
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Output-side acker: mirrors out_req when automatic, else the manual value.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            out_ack = auto_ack ? out_req : manual_ack;
        end
    end

    // Monitor: scoreboard compare of every meaningful output cycle.
    initial begin
        logic [4:0]   prev_req;
        logic [W-1:0] prev_data;
        prev_req  = 5'b00000;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b0) begin
                prev_req = 5'b00000;
            end else begin
                chk("onehot", 64'($onehot0(out_req)), 64'd1);
                if (out_req != 5'b00000) begin
                    if (prev_req != 5'b00000) chk("data_stable", 64'(out_data), 64'(prev_data));
                    if (prev_req == 5'b00000) begin
                        req_log.push_back(out_req);
                        data_log.push_back(out_data);
                    end
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_out actual=out_req 0x%0h required=no request", out_req);
                    end else begin
                        chk("out_data", 64'(out_data), 64'(exp_q[0]));
                        chk("out_req", 64'(out_req), 64'(exp_onehot(exp_q[0])));
                        if ((out_req & out_ack) != 5'b00000) begin
                            void'(exp_q.pop_front());
                            recv_count++;
                        end
                    end
                end
                prev_req  = out_req;
                prev_data = out_data;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] p, pa, pb, pc;
        logic [W-1:0] t2_pkt [5];
        logic [4:0]   t2_req [5];
        int           t2_dx [5];
        int           t2_dy [5];
        int           n, rc0;
        t2_req = '{5'b00100, 5'b10000, 5'b00010, 5'b01000, 5'b00001};
        t2_dx  = '{2, 0, 1, 1, 1};
        t2_dy  = '{1, 1, 2, 0, 1};

        reset = 1'b1; in_req = 1'b0; in_data = '0;
        @(posedge clk); #1;
        chk("rst_in_ack", 64'(in_ack), 64'd0);
        chk("rst_out_req", 64'(out_req), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // T1: reset in the middle of both handshakes
        auto_ack = 1'b0; manual_ack = 5'b00000;
        p = mk(2, 1);
        exp_q.push_back(p);
        in_data = p; in_req = 1'b1;
        n = 0;
        while (out_req == 5'b00000 && n < 20) begin @(posedge clk); #1; n++; end
        chk("t1_pre_in_ack", 64'(in_ack), 64'd1);
        chk("t1_pre_out_req", 64'(out_req), 64'b00100);
        reset = 1'b1; in_req = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        chk("t1_in_ack", 64'(in_ack), 64'd0);
        chk("t1_out_req", 64'(out_req), 64'd0);
        chk("t1_out_data", 64'(out_data), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            chk("t1_fifo_empty", 64'(out_req), 64'd0);
        end

        // T2: one packet per direction, eager acks
        auto_ack = 1'b1;
        req_log.delete(); data_log.delete();
        for (int i = 0; i < 5; i++) begin
            t2_pkt[i] = mk(t2_dx[i], t2_dy[i]);
            send(t2_pkt[i]);
        end
        wait_drain();
        chk("t2_count", 64'(req_log.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < req_log.size()) begin
                chk("t2_req", 64'(req_log[i]), 64'(t2_req[i]));
                chk("t2_data", 64'(data_log[i]), 64'(t2_pkt[i]));
            end
        end

        // T3: latency from an empty FIFO
        p = mk(3, 1);
        exp_q.push_back(p);
        in_data = p; in_req = 1'b1;
        @(posedge clk); #1;
        chk("t3_in_ack_n", 64'(in_ack), 64'd1);
        chk("t3_out_req_n", 64'(out_req), 64'd0);
        @(posedge clk); #1;
        chk("t3_out_req_n1", 64'(out_req), 64'b00100);
        chk("t3_out_data_n1", 64'(out_data), 64'(p));
        in_req = 1'b0;
        wait_drain();

        // T4: backpressure with a full FIFO
        auto_ack = 1'b0; manual_ack = 5'b00000;
        @(posedge clk); #1;
        pa = mk(0, 1); pb = mk(1, 2); pc = mk(1, 0);
        send(pa);
        send(pb);
        exp_q.push_back(pc);
        in_data = pc; in_req = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            chk("t4_blocked", 64'(in_ack), 64'd0);
        end
        chk("t4_head_req", 64'(out_req), 64'b10000);
        auto_ack = 1'b1;
        @(posedge clk); #1;
        chk("t4_pop_cycle", 64'(in_ack), 64'd0);
        @(posedge clk); #1;
        chk("t4_unblocked", 64'(in_ack), 64'd1);
        in_req = 1'b0;
        wait_drain();

        // T5: acks on other ports are ignored
        auto_ack = 1'b0; manual_ack = 5'b00000;
        @(posedge clk); #1;
        send(mk(2, 3));
        n = 0;
        while (out_req == 5'b00000 && n < 20) begin @(posedge clk); #1; n++; end
        manual_ack = 5'b00010;
        repeat (4) begin
            @(posedge clk); #1;
            chk("t5_hold", 64'(out_req), 64'b00100);
        end
        manual_ack = 5'b00100;
        @(posedge clk); #1;
        chk("t5_release", 64'(out_req), 64'd0);
        manual_ack = 5'b00000;
        wait_drain();

        // T6: 100 random-destination packets back to back
        auto_ack = 1'b1;
        rc0 = recv_count;
        for (int i = 0; i < 100; i++) begin
            send(mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 3))));
        end
        wait_drain();
        chk("t6_received", 64'(recv_count - rc0), 64'd100);
        chk("t6_leftover", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
